mc_core_p: RTL and testbench
============================

# mc_core_p

Parametrised multicycle MIPS core: the next-generation successor of the team's multicycle datapath. It merges the datapath and its controller FSM into one block and replaces the fixed single-cycle memory with a req/ready handshake, so memory latency can vary. It adds bne, a configurable reset PC and illegal-opcode handling. It is the top-level compute block and connects to an external unified instruction/data memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- ADDR_W, 32, width of mem_addr (1..32); it carries the low ADDR_W bits of the byte address.
- HALT_ON_ILLEGAL, 1, 1: an unsupported opcode/funct enters HALT; 0: it retires as a nop.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory access request; held high until accepted.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  byte address; stable while mem_req is high.
- mem_wdata  out  32  write data (B register); stable while mem_req && mem_we.
- mem_rdata  in  32  read data; sampled on the edge where mem_req && mem_ready.
- mem_ready  in  1  access completes on the rising edge where mem_req && mem_ready.
- dbg_sel  in  5  register-file debug read index.
- dbg_data  out  32  combinational regfile[dbg_sel]; reads 0 when dbg_sel = 0.
- pc  out  32  current PC register.
- retire  out  1  one-cycle pulse in the final cycle of each instruction.
- halted  out  1  high in HALT.

## Operation
- Internal state: PC, IR, MDR, A, B, ALUOut, a 32x32 register file and the FSM. $0 reads 0, and writes to $0 are discarded.
- Supported instructions:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
  - lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, j 0x02.
- Arithmetic is 32-bit and wraps; there are no overflow traps.
- Sign extension: imm16 is sign-extended to 32 bits. The branch offset is sext(imm16)<<2.
- Jump target: {PC[31:28], IR[25:0], 2'b00}, where PC is already incremented.
- FSM states, in the order they are entered:
  - IDLE (reset state) -> FETCH unconditionally.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stays until mem_ready. On acceptance: IR<=mem_rdata, PC<=PC+4, -> DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(sext<<2). Dispatch by opcode:
    - R-type -> EXR; lw/sw -> MADDR; beq/bne -> BR; j -> JMP; addi -> EXI.
    - Illegal -> HALT, or -> FETCH with retire=1 when HALT_ON_ILLEGAL=0.
  - EXR: ALUOut<=A op B -> WBR. WBR: rf[rd]<=ALUOut, retire=1 -> FETCH.
  - EXI: ALUOut<=A+sext -> WBI. WBI: rf[rt]<=ALUOut, retire=1 -> FETCH.
  - MADDR: ALUOut<=A+sext -> MRD for lw, MWR for sw.
  - MRD: mem_req=1, mem_we=0, mem_addr=ALUOut; wait for mem_ready, then MDR<=mem_rdata -> WBM.
  - WBM: rf[rt]<=MDR, retire=1 -> FETCH.
  - MWR: mem_req=1, mem_we=1, mem_addr=ALUOut, mem_wdata=B; wait for mem_ready, then retire=1 -> FETCH.
  - BR: if (A==B) XOR bne, then PC<=ALUOut. retire=1 -> FETCH.
  - JMP: PC<=jump target, retire=1 -> FETCH.
  - HALT: terminal; only rst_n leaves it. mem_req=0, halted=1.
- mem_req, mem_we and mem_addr decode from the state and registers, not from mem_ready. Once mem_req is asserted it is never withdrawn before acceptance, except by reset.
- Unaligned addresses are not checked; the low 2 bits pass through unchanged.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state IDLE, pc=RESET_PC.
  - mem_req=0, mem_we=0, retire=0, halted=0.
  - IR, A, B, MDR and ALUOut are 0; register file contents are 0.
- The first FETCH request appears in the second cycle after rst_n deasserts.
- Reset asserted during a pending request drops mem_req in the same instant. The memory must tolerate the abandoned access.
- Cycle counts with mem_ready tied high (counted from the first FETCH cycle to the retire cycle inclusive):
  - R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3.
- Each wait cycle on mem_ready adds exactly one cycle to its state.
- The next FETCH follows retire with no gap.
- Register-file writes occur on the edge that ends the WB state. A register written in WB is visible through dbg_data in the cycle after that edge.

## Test plan
- Reset: hold rst_n=0 with RESET_PC=32'h40 -> pc=0x40 and mem_req=0. After release, the first mem_req has mem_addr=0x40 exactly 2 cycles later.
- ALU: program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$2,$1; slt $5,$2,$1 (ready tied high).
  - Expect $3=2, $4=0xFFFFFFF8, $5=1.
  - Expect retire pulses spaced 4 cycles apart.
- Memory with variable latency: sw $1,8($0), then lw $6,8($0), with mem_ready delayed 3 cycles per access.
  - Expect $6=5 and one write at addr 8 with data 5.
  - Expect the lw to retire after 5+3+3 cycles.
  - Expect mem_addr/mem_we stable throughout each wait.
- Control flow: beq taken (offset +2) skips two instructions, bne with equal operands falls through, and j 0x10 sets pc=0x40.
  - Each branch/jump retires in 3 cycles.
- Illegal opcode 0x3F:
  - HALT_ON_ILLEGAL=1 -> halted=1 and mem_req stays low forever.
  - HALT_ON_ILLEGAL=0 -> retires as a nop after 2 cycles and fetches the next word.
- Writes to $0 (add $0,$1,$1) leave dbg_data(0)=0. Reset asserted mid-MRD wait -> mem_req drops immediately and the core restarts at RESET_PC.

Source files
------------

// File: rtl/mc_core_p_if.sv
// mc_core_p_if: memory bus between mc_core_p and a unified instruction/data memory.
//   mem_req   core -> mem  access request, held until accepted
//   mem_we    core -> mem  1 = write, 0 = read
//   mem_addr  core -> mem  byte address (low ADDR_W bits)
//   mem_wdata core -> mem  write data
//   mem_rdata mem -> core  read data, sampled on acceptance
//   mem_ready mem -> core  access completes on the edge where mem_req && mem_ready
interface mc_core_p_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mc_core_p.sv
// mc_core_p: multicycle MIPS core (add/sub/and/or/slt, lw, sw, beq, bne, addi, j)
// with a req/ready memory handshake.
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   mem      bus  master side of mc_core_p_if (instruction and data accesses)
//   dbg_sel  in   register-file debug read index
//   dbg_data out  regfile[dbg_sel], 0 for index 0
//   pc       out  current PC register
//   retire   out  pulse in the final cycle of each instruction
//   halted   out  high in HALT
module mc_core_p #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int unsigned ADDR_W          = 32,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   mc_core_p_if.master   mem,
   input  logic [4:0]    dbg_sel,
   output logic [31:0]   dbg_data,
   output logic [31:0]   pc,
   output logic          retire,
   output logic          halted
);
   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXR, WBR, EXI, WBI, MADDR, MRD, WBM, MWR, BR, JMP, HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   state_t            state;
   logic [31:0]       ir, mdr, a, b, alu_out;
   logic [31:0]       rf [32];
   logic              req_r, we_r, retire_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       wdata_r;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext, ea, alu_r, jump_target, br_target;
   logic        taken, accept;

   function automatic logic is_legal(input logic [31:0] w);
      logic ok;
      ok = 1'b0;
      case (w[31:26])
         OP_RTYPE: ok = (w[5:0] == FN_ADD) || (w[5:0] == FN_SUB) || (w[5:0] == FN_AND) ||
                        (w[5:0] == FN_OR)  || (w[5:0] == FN_SLT);
         OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign op          = ir[31:26];
   assign rs          = ir[25:21];
   assign rt          = ir[20:16];
   assign rd          = ir[15:11];
   assign funct       = ir[5:0];
   assign imm_sext    = {{16{ir[15]}}, ir[15:0]};
   assign ea          = a + imm_sext;
   assign jump_target = {pc[31:28], ir[25:0], 2'b00};
   assign taken       = (a == b) ^ (op == OP_BNE);
   assign br_target   = taken ? alu_out : pc;
   assign accept      = req_r && mem.mem_ready;

   always_comb begin
      alu_r = '0;
      case (funct)
         FN_ADD:  alu_r = a + b;
         FN_SUB:  alu_r = a - b;
         FN_AND:  alu_r = a & b;
         FN_OR:   alu_r = a | b;
         FN_SLT:  alu_r = {31'b0, $signed(a) < $signed(b)};
         default: alu_r = '0;
      endcase
   end

   assign mem.mem_req   = req_r;
   assign mem.mem_we    = we_r;
   assign mem.mem_addr  = addr_r;
   assign mem.mem_wdata = wdata_r;
   assign dbg_data      = (dbg_sel == 5'd0) ? '0 : rf[dbg_sel];
   // A store retires in the cycle its write is accepted, which depends on
   // mem_ready in that same cycle, so that one case cannot be registered.
   assign retire        = retire_r | (state == MWR && accept);

   // Every transition into FETCH/MRD/MWR loads the request registers, so the
   // bus is valid from the first cycle of the state and stable while waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         ir       <= '0;
         mdr      <= '0;
         a        <= '0;
         b        <= '0;
         alu_out  <= '0;
         req_r    <= 1'b0;
         we_r     <= 1'b0;
         addr_r   <= '0;
         wdata_r  <= '0;
         retire_r <= 1'b0;
         halted   <= 1'b0;
         for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
      end else begin
         retire_r <= 1'b0;
         case (state)
            IDLE: begin
               state  <= FETCH;
               req_r  <= 1'b1;
               we_r   <= 1'b0;
               addr_r <= pc[ADDR_W-1:0];
            end
            FETCH: if (accept) begin
               ir    <= mem.mem_rdata;
               pc    <= pc + 32'd4;
               req_r <= 1'b0;
               state <= DECODE;
               // Illegal words retiring as a nop retire in DECODE; decide it here.
               retire_r <= !HALT_ON_ILLEGAL && !is_legal(mem.mem_rdata);
            end
            DECODE: begin
               a       <= rf[rs];
               b       <= rf[rt];
               alu_out <= pc + (imm_sext << 2);
               if (!is_legal(ir)) begin
                  if (HALT_ON_ILLEGAL) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     state  <= FETCH;
                     req_r  <= 1'b1;
                     we_r   <= 1'b0;
                     addr_r <= pc[ADDR_W-1:0];
                  end
               end else begin
                  case (op)
                     OP_RTYPE:      state <= EXR;
                     OP_LW, OP_SW:  state <= MADDR;
                     OP_BEQ, OP_BNE: begin
                        state    <= BR;
                        retire_r <= 1'b1;
                     end
                     OP_J: begin
                        state    <= JMP;
                        retire_r <= 1'b1;
                     end
                     default:       state <= EXI;
                  endcase
               end
            end
            EXR: begin
               alu_out  <= alu_r;
               state    <= WBR;
               retire_r <= 1'b1;
            end
            EXI: begin
               alu_out  <= ea;
               state    <= WBI;
               retire_r <= 1'b1;
            end
            WBR, WBI, WBM: begin
               if (state == WBR) begin
                  if (rd != 5'd0) rf[rd] <= alu_out;
               end else if (rt != 5'd0) begin
                  rf[rt] <= (state == WBM) ? mdr : alu_out;
               end
               state  <= FETCH;
               req_r  <= 1'b1;
               we_r   <= 1'b0;
               addr_r <= pc[ADDR_W-1:0];
            end
            MADDR: begin
               alu_out <= ea;
               req_r   <= 1'b1;
               addr_r  <= ea[ADDR_W-1:0];
               wdata_r <= b;
               if (op == OP_SW) begin
                  we_r  <= 1'b1;
                  state <= MWR;
               end else begin
                  we_r  <= 1'b0;
                  state <= MRD;
               end
            end
            MRD: if (accept) begin
               mdr      <= mem.mem_rdata;
               req_r    <= 1'b0;
               state    <= WBM;
               retire_r <= 1'b1;
            end
            MWR: if (accept) begin
               state  <= FETCH;
               we_r   <= 1'b0;
               addr_r <= pc[ADDR_W-1:0];
            end
            BR: begin
               pc     <= br_target;
               state  <= FETCH;
               req_r  <= 1'b1;
               we_r   <= 1'b0;
               addr_r <= br_target[ADDR_W-1:0];
            end
            JMP: begin
               pc     <= jump_target;
               state  <= FETCH;
               req_r  <= 1'b1;
               we_r   <= 1'b0;
               addr_r <= jump_target[ADDR_W-1:0];
            end
            HALT: begin
               req_r <= 1'b0;
               we_r  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_core_p.sv
// tb_mc_core_p: directed bench for mc_core_p. dut_a (RESET_PC=0x40, halts on
// illegal opcodes) runs reset, ALU, variable-latency memory, control-flow,
// illegal-halt and mid-access reset programs; dut_b (RESET_PC=0, illegal
// opcodes retire as nops) runs the nop program.
module tb_mc_core_p;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic [4:0]  dbg_sel_a, dbg_sel_b;
   logic [31:0] dbg_a, dbg_b, pc_a, pc_b;
   logic        retire_a, retire_b, halted_a, halted_b;
   int          n_chk = 0;
   int          n_fail = 0;

   mc_core_p_if #(.ADDR_W(32)) bus_a ();
   mc_core_p_if #(.ADDR_W(32)) bus_b ();

   mc_core_p #(.RESET_PC(32'h40), .ADDR_W(32), .HALT_ON_ILLEGAL(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_a), .mem(bus_a), .dbg_sel(dbg_sel_a),
      .dbg_data(dbg_a), .pc(pc_a), .retire(retire_a), .halted(halted_a));

   mc_core_p #(.RESET_PC(32'h0), .ADDR_W(32), .HALT_ON_ILLEGAL(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_b), .mem(bus_b), .dbg_sel(dbg_sel_b),
      .dbg_data(dbg_b), .pc(pc_b), .retire(retire_b), .halted(halted_b));

   // Memory A: 64 words, mem_ready raised after lat_a wait cycles.
   logic [31:0] mem_a [64];
   int unsigned lat_a = 0, cnt_a = 0, wr_n = 0;
   logic [31:0] wr_addr = '0, wr_data = '0;
   assign bus_a.mem_rdata = mem_a[bus_a.mem_addr[7:2]];
   assign bus_a.mem_ready = bus_a.mem_req && (cnt_a >= lat_a);
   always @(posedge clk) begin
      if (!rst_a) cnt_a <= 0;
      else if (bus_a.mem_req && bus_a.mem_ready) begin
         cnt_a <= 0;
         if (bus_a.mem_we) begin
            mem_a[bus_a.mem_addr[7:2]] <= bus_a.mem_wdata;
            wr_n    <= wr_n + 1;
            wr_addr <= bus_a.mem_addr;
            wr_data <= bus_a.mem_wdata;
         end
      end else if (bus_a.mem_req) cnt_a <= cnt_a + 1;
   end

   // Memory B: read-only, zero latency.
   logic [31:0] mem_b [64];
   assign bus_b.mem_rdata = mem_b[bus_b.mem_addr[7:2]];
   assign bus_b.mem_ready = bus_b.mem_req;

   // Request stability: a request still waiting must keep req/addr/we.
   logic        pend = 1'b0, pend_we = 1'b0;
   logic [31:0] pend_addr = '0;
   int unsigned viol = 0;
   always @(negedge clk) begin
      if (rst_a && pend && (!bus_a.mem_req || bus_a.mem_addr != pend_addr || bus_a.mem_we != pend_we))
         viol <= viol + 1;
      pend      <= rst_a && bus_a.mem_req && !bus_a.mem_ready;
      pend_addr <= bus_a.mem_addr;
      pend_we   <= bus_a.mem_we;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic wait_retire(input bit use_b, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(use_b ? retire_b : retire_a) && n < 40);
   endtask

   task automatic clear_a();
      for (int i = 0; i < 64; i++) mem_a[i] = '0;
   endtask

   int n, req_cnt, ret_cnt;
   bit found;

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; dbg_sel_a = '0; dbg_sel_b = '0;

      // ---- Reset and ALU program ----
      clear_a();
      mem_a[16] = 32'h20010005;  // addi $1,$0,5
      mem_a[17] = 32'h2002FFFD;  // addi $2,$0,-3
      mem_a[18] = 32'h00221820;  // add  $3,$1,$2
      mem_a[19] = 32'h00412022;  // sub  $4,$2,$1
      mem_a[20] = 32'h0041282A;  // slt  $5,$2,$1
      mem_a[21] = 32'h00210020;  // add  $0,$1,$1
      mem_a[22] = 32'h08000016;  // j    self
      repeat (2) @(negedge clk);
      chk("reset_pc", pc_a, 32'h40);
      chk("reset_req", {31'b0, bus_a.mem_req}, 32'd0);
      chk("reset_retire", {31'b0, retire_a}, 32'd0);
      chk("reset_halted", {31'b0, halted_a}, 32'd0);
      rst_a = 1'b1;
      #1 chk("idle_req", {31'b0, bus_a.mem_req}, 32'd0);
      @(posedge clk); #1;
      chk("first_req", {31'b0, bus_a.mem_req}, 32'd1);
      chk("first_addr", bus_a.mem_addr, 32'h40);
      for (int i = 0; i < 6; i++) begin
         wait_retire(1'b0, n);
         chk("alu_retire_gap", n, 4);
      end
      @(negedge clk);
      dbg_sel_a = 5'd3; #1 chk("add_r3", dbg_a, 32'd2);
      dbg_sel_a = 5'd4; #1 chk("sub_r4", dbg_a, 32'hFFFFFFF8);
      dbg_sel_a = 5'd5; #1 chk("slt_r5", dbg_a, 32'd1);
      dbg_sel_a = 5'd0; #1 chk("r0_zero", dbg_a, 32'd0);

      // ---- Store/load with 3 wait cycles per access ----
      @(negedge clk); rst_a = 1'b0;
      clear_a();
      mem_a[16] = 32'h20010005;  // addi $1,$0,5
      mem_a[17] = 32'hAC010008;  // sw   $1,8($0)
      mem_a[18] = 32'h8C060008;  // lw   $6,8($0)
      mem_a[19] = 32'h08000013;  // j    self
      lat_a = 3;
      @(negedge clk); rst_a = 1'b1;
      begin
         int base;
         base = int'(wr_n);
         wait_retire(1'b0, n); chk("lat_addi_cycles", n, 7);
         wait_retire(1'b0, n); chk("lat_sw_cycles", n, 10);
         wait_retire(1'b0, n); chk("lat_lw_cycles", n, 11);
         @(negedge clk);
         dbg_sel_a = 5'd6; #1 chk("lw_r6", dbg_a, 32'd5);
         chk("write_count", int'(wr_n) - base, 1);
      end
      chk("write_addr", wr_addr, 32'd8);
      chk("write_data", wr_data, 32'd5);
      chk("req_stable", viol, 32'd0);

      // ---- Control flow ----
      @(negedge clk); rst_a = 1'b0;
      clear_a();
      mem_a[16] = 32'h20010001;  // addi $1,$0,1
      mem_a[17] = 32'h10210002;  // beq  $1,$1,+2
      mem_a[18] = 32'h20020007;  // addi $2,$0,7 (skipped)
      mem_a[19] = 32'h20020008;  // addi $2,$0,8 (skipped)
      mem_a[20] = 32'h14210002;  // bne  $1,$1,+2 (not taken)
      mem_a[21] = 32'h20030003;  // addi $3,$0,3
      mem_a[22] = 32'h08000010;  // j    0x10 -> 0x40
      lat_a = 0;
      @(negedge clk); rst_a = 1'b1;
      wait_retire(1'b0, n); chk("cf_addi_cycles", n, 4);
      wait_retire(1'b0, n); chk("beq_cycles", n, 3);
      @(posedge clk); #1;
      chk("beq_pc", pc_a, 32'h50);
      chk("beq_fetch_addr", bus_a.mem_addr, 32'h50);
      wait_retire(1'b0, n); chk("bne_cycles", n, 3);
      @(posedge clk); #1;
      chk("bne_pc", pc_a, 32'h54);
      wait_retire(1'b0, n); chk("cf_addi3_cycles", n, 4);
      wait_retire(1'b0, n); chk("j_cycles", n, 3);
      @(posedge clk); #1;
      chk("j_pc", pc_a, 32'h40);
      dbg_sel_a = 5'd2; #1 chk("skipped_r2", dbg_a, 32'd0);
      dbg_sel_a = 5'd3; #1 chk("fallthru_r3", dbg_a, 32'd3);

      // ---- Illegal opcode, halting core ----
      @(negedge clk); rst_a = 1'b0;
      clear_a();
      mem_a[16] = 32'hFC000000;
      @(negedge clk); rst_a = 1'b1;
      req_cnt = 0; ret_cnt = 0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus_a.mem_req) req_cnt++;
         if (retire_a) ret_cnt++;
      end
      chk("halt_halted", {31'b0, halted_a}, 32'd1);
      chk("halt_req_low", req_cnt, 0);
      chk("halt_no_retire", ret_cnt, 0);
      chk("halt_pc", pc_a, 32'h44);

      // ---- Illegal opcode, nop core ----
      for (int i = 0; i < 64; i++) mem_b[i] = '0;
      mem_b[0] = 32'hFC000000;   // illegal
      mem_b[1] = 32'h20070009;   // addi $7,$0,9
      mem_b[2] = 32'h08000002;   // j    self
      @(negedge clk); rst_b = 1'b1;
      wait_retire(1'b1, n); chk("nop_cycles", n, 2);
      @(posedge clk); #1;
      chk("nop_next_req", {31'b0, bus_b.mem_req}, 32'd1);
      chk("nop_next_addr", bus_b.mem_addr, 32'h4);
      wait_retire(1'b1, n); chk("nop_addi_cycles", n, 4);
      @(negedge clk);
      dbg_sel_b = 5'd7; #1 chk("nop_r7", dbg_b, 32'd9);
      chk("nop_not_halted", {31'b0, halted_b}, 32'd0);

      // ---- Reset during a pending load ----
      @(negedge clk); rst_a = 1'b0;
      clear_a();
      mem_a[16] = 32'h8C060008;  // lw $6,8($0)
      mem_a[17] = 32'h08000011;  // j  self
      lat_a = 5;
      @(negedge clk); rst_a = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         found = bus_a.mem_req && !bus_a.mem_we && bus_a.mem_addr == 32'd8;
      end
      chk("mrd_reached", {31'b0, found}, 32'd1);
      @(negedge clk);
      chk("mrd_pc", pc_a, 32'h44);
      rst_a = 1'b0;
      #1;
      chk("rst_drops_req", {31'b0, bus_a.mem_req}, 32'd0);
      chk("rst_pc", pc_a, 32'h40);
      @(negedge clk); rst_a = 1'b1;
      @(posedge clk); #1;
      chk("restart_req", {31'b0, bus_a.mem_req}, 32'd1);
      chk("restart_addr", bus_a.mem_addr, 32'h40);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
